load_queue: RTL and testbench
=============================

LOAD_QUEUE -- requirements
Module: load_queue
Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2); IW=clog2(DEPTH).
REQ-002 SHALL have parameter ADDR_W, default 32, physical address and load data width.
REQ-003 SHALL have parameter PREG_W, default 7, rename register index width.
REQ-004 SHALL have parameter ROB_W, default 6, ROB pointer width.
REQ-005 SHALL have parameter RET_W, default 4, maximum retires per cycle.
REQ-006 SHALL have port Clk  in  1  single clock, all logic on posedge.
REQ-007 SHALL have port Rest  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port Stall  in  1  freeze allocate/issue/retire/barrier state.
REQ-009 SHALL have port Flush  in  1  discard all entries.
REQ-010 SHALL have port StopReq  out  1  upstream must hold its input.
REQ-011 SHALL have port SbEmpty  in  1  store buffer empty.
REQ-012 SHALL have port InValid  in  1  allocate request.
REQ-013 SHALL have port InBar  in  1  request is IBAR/DBAR, not a load.
REQ-014 SHALL have port InMat  in  2  memory access type.
REQ-015 SHALL have port InPAddr  in  ADDR_W  physical address.
REQ-016 SHALL have port InWbAble  in  1  load writes a register.
REQ-017 SHALL have port InWbAddr  in  PREG_W  destination register.
REQ-018 SHALL have port InRobPtr  in  ROB_W  ROB slot.
REQ-019 SHALL have ports DcReqValid out 1 / DcReqReady in 1: Dcache request handshake.
REQ-020 SHALL have ports DcReqMat out 2 / DcReqAddr out ADDR_W: request payload.
REQ-021 SHALL have port DcReqTag  out  IW+1  {generation bit, entry index}.
REQ-022 SHALL have ports DcRespValid in 1 / DcRespTag in IW+1 / DcRespNack in 1: Dcache response.
REQ-023 SHALL have ports WbValid out 1 / WbAddr out PREG_W: register writeback; data is DcRespData (in ADDR_W), consumed directly.
REQ-024 SHALL have ports CmtValid out 1 / CmtRobPtr out ROB_W: completion to ROB.
REQ-025 SHALL have port RetireCnt  in  clog2(RET_W+1)  entries retired from head this cycle.
Function
REQ-026 Entries SHALL form a circular queue (head/tail IW+1 bits, wrap bit); per-entry state FREE->WAIT_ISS (alloc)->WAIT_RESP (handshake)->DONE (good resp)->FREE (retire); nack: WAIT_RESP->WAIT_ISS.
REQ-027 Alloc when InValid & ~InBar & ~StopReq: write tail, tail+1; allocation in the same cycle as retire is allowed.
REQ-028 StopReq SHALL equal BarPend | (InValid & InBar) | full, full taken from registered count before same-cycle retire.
REQ-029 InValid & InBar & ~StopReq-by-full SHALL set BarPend without allocating; BarPend clears the cycle after queue empty & SbEmpty.
REQ-030 Issue SHALL pick the oldest WAIT_ISS entry from head; DcReqValid/payload stable until DcReqReady; Stall forces DcReqValid=0.
REQ-031 Each entry's generation bit SHALL toggle on every allocation; response with stale generation or entry not in WAIT_RESP SHALL be dropped silently.
REQ-032 Accepted non-nack response SHALL assert CmtValid/CmtRobPtr the same cycle (combinational), WbValid = CmtValid & entry WbAble; responses are processed even under Stall.
REQ-033 Retire SHALL free RetireCnt entries from head in order; retiring a non-DONE entry or RetireCnt>count is illegal (bench assertion).
REQ-034 Priority: Rest > Flush > Stall; Flush frees all entries, head=tail=0, BarPend=0, generation bits kept.
Reset
REQ-035 Rest SHALL clear all state/generation bits, head=tail=0, BarPend=0; all outputs 0 (StopReq=0 unless InValid&InBar).
Structure
REQ-036 Entry-state encoding and tag-field layout SHALL be in the shared core package; oldest-ready selection SHALL be sub-module lq_oldest_pick (head-rotated priority encoder).
Verification
REQ-037 DEPTH=8: 8 allocs, no resp -> StopReq=1 on 9th cycle; RetireCnt=0 keeps full.
REQ-038 Issue to entries 0,1; resp tag 1 then 0 -> CmtRobPtr order 1 then 0, same cycle as resp.
REQ-039 Resp nack on entry 2 -> entry 2 reissued before younger entry 3, DcReqAddr unchanged.
REQ-040 Flush with entry 0 in WAIT_RESP, realloc entry 0, stale-tag resp arrives -> no CmtValid.
REQ-041 InBar with 3 live entries, SbEmpty=0 -> StopReq held until all retired and SbEmpty=1, then drops next cycle.

Source files
------------

// File: rtl/load_queue_pkg.sv
// rtl/load_queue_pkg.sv - shared load-queue entry states and Dcache tag layout
package load_queue_pkg;

  typedef enum logic [1:0] {
    LQ_FREE      = 2'd0,
    LQ_WAIT_ISS  = 2'd1,
    LQ_WAIT_RESP = 2'd2,
    LQ_DONE      = 2'd3
  } lq_state_e;

  // Dcache tag is {generation, entry index}: generation bit sits just above the index.
  function automatic int lq_tag_w(input int iw);
    return iw + 1;
  endfunction

endpackage

// File: rtl/load_queue_if.sv
// rtl/load_queue_if.sv - load-queue allocate, Dcache, writeback and retire signal bundle
interface load_queue_if import load_queue_pkg::*; #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 6,
  parameter int RET_W  = 4
);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = lq_tag_w(IW);
  localparam int CW = $clog2(RET_W + 1);

  logic              Stall;
  logic              Flush;
  logic              StopReq;
  logic              SbEmpty;
  logic              InValid;
  logic              InBar;
  logic [1:0]        InMat;
  logic [ADDR_W-1:0] InPAddr;
  logic              InWbAble;
  logic [PREG_W-1:0] InWbAddr;
  logic [ROB_W-1:0]  InRobPtr;
  logic              DcReqValid;
  logic              DcReqReady;
  logic [1:0]        DcReqMat;
  logic [ADDR_W-1:0] DcReqAddr;
  logic [TW-1:0]     DcReqTag;
  logic              DcRespValid;
  logic [TW-1:0]     DcRespTag;
  logic              DcRespNack;
  logic [ADDR_W-1:0] DcRespData;
  logic              WbValid;
  logic [PREG_W-1:0] WbAddr;
  logic              CmtValid;
  logic [ROB_W-1:0]  CmtRobPtr;
  logic [CW-1:0]     RetireCnt;

  modport master (
    input  Stall, Flush, SbEmpty, InValid, InBar, InMat, InPAddr, InWbAble, InWbAddr, InRobPtr,
    input  DcReqReady, DcRespValid, DcRespTag, DcRespNack, DcRespData, RetireCnt,
    output StopReq, DcReqValid, DcReqMat, DcReqAddr, DcReqTag, WbValid, WbAddr, CmtValid, CmtRobPtr
  );

  modport slave (
    output Stall, Flush, SbEmpty, InValid, InBar, InMat, InPAddr, InWbAble, InWbAddr, InRobPtr,
    output DcReqReady, DcRespValid, DcRespTag, DcRespNack, DcRespData, RetireCnt,
    input  StopReq, DcReqValid, DcReqMat, DcReqAddr, DcReqTag, WbValid, WbAddr, CmtValid, CmtRobPtr
  );

endinterface

// File: rtl/lq_oldest_pick.sv
// rtl/lq_oldest_pick.sv - head-rotated priority encoder: first requesting entry at or after base
module lq_oldest_pick #(
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  input  logic [IW-1:0]    base,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // Scan youngest to oldest so the oldest hit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = base;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (req[base + IW'(k)]) begin
        valid = 1'b1;
        idx   = base + IW'(k);
      end
    end
  end

endmodule

// File: rtl/load_queue.sv
// rtl/load_queue.sv - in-order load queue with out-of-order Dcache responses and barrier stall
module load_queue import load_queue_pkg::*; #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 6,
  parameter int RET_W  = 4
) (
  input logic          Clk,
  input logic          Rest,
  load_queue_if.master lq
);

  localparam int IW = $clog2(DEPTH);
  localparam int TW = lq_tag_w(IW);

  lq_state_e         st   [DEPTH];
  lq_state_e         st_n [DEPTH];
  logic [DEPTH-1:0]  gen;
  logic [DEPTH-1:0]  wbable;
  logic [1:0]        mat    [DEPTH];
  logic [ADDR_W-1:0] paddr  [DEPTH];
  logic [PREG_W-1:0] wbaddr [DEPTH];
  logic [ROB_W-1:0]  robptr [DEPTH];

  logic [IW:0]      head, tail, count;
  logic [IW-1:0]    head_idx, tail_idx;
  logic             full, empty, bar_pend, bar_req, alloc;
  logic [DEPTH-1:0] iss_req;
  logic             pick_valid, iss_lock, iss_fire;
  logic [IW-1:0]    pick_idx, iss_hold, iss_idx;
  logic [IW-1:0]    rsp_idx;
  logic             rsp_hit;
  logic [TW-1:0]    req_tag;

  assign count    = tail - head;
  assign full     = count[IW];
  assign empty    = (count == '0);
  assign head_idx = head[IW-1:0];
  assign tail_idx = tail[IW-1:0];

  assign lq.StopReq = bar_pend | (lq.InValid & lq.InBar) | full;
  assign alloc      = lq.InValid & ~lq.InBar & ~lq.StopReq & ~lq.Stall;
  assign bar_req    = lq.InValid & lq.InBar & ~full;

  always_comb begin
    iss_req = '0;
    for (int i = 0; i < DEPTH; i++) iss_req[i] = (st[i] == LQ_WAIT_ISS);
  end

  lq_oldest_pick #(.DEPTH(DEPTH), .IW(IW)) u_pick (
    .req   (iss_req),
    .base  (head_idx),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // A request left waiting on DcReqReady is pinned so its payload cannot shift under the cache.
  assign iss_idx       = iss_lock ? iss_hold : pick_idx;
  assign req_tag       = {gen[iss_idx], iss_idx};
  assign lq.DcReqValid = (iss_lock | pick_valid) & ~lq.Stall & ~lq.Flush;
  assign lq.DcReqMat   = mat[iss_idx];
  assign lq.DcReqAddr  = paddr[iss_idx];
  assign lq.DcReqTag   = req_tag;
  assign iss_fire      = lq.DcReqValid & lq.DcReqReady;

  assign rsp_idx      = lq.DcRespTag[IW-1:0];
  assign rsp_hit      = lq.DcRespValid && (st[rsp_idx] == LQ_WAIT_RESP) &&
                        (gen[rsp_idx] == lq.DcRespTag[IW]);
  assign lq.CmtValid  = rsp_hit & ~lq.DcRespNack;
  assign lq.CmtRobPtr = lq.CmtValid ? robptr[rsp_idx] : '0;
  assign lq.WbValid   = lq.CmtValid & wbable[rsp_idx];
  assign lq.WbAddr    = lq.WbValid ? wbaddr[rsp_idx] : '0;

  always_comb begin
    st_n = st;
    for (int k = 0; k < RET_W; k++) begin
      if (!lq.Stall && k < int'(lq.RetireCnt)) st_n[head_idx + IW'(k)] = LQ_FREE;
    end
    if (rsp_hit) st_n[rsp_idx] = lq.DcRespNack ? LQ_WAIT_ISS : LQ_DONE;
    if (iss_fire) st_n[iss_idx] = LQ_WAIT_RESP;
    if (alloc) st_n[tail_idx] = LQ_WAIT_ISS;
    if (lq.Flush) begin
      for (int i = 0; i < DEPTH; i++) st_n[i] = LQ_FREE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      head     <= '0;
      tail     <= '0;
      bar_pend <= 1'b0;
      iss_lock <= 1'b0;
      iss_hold <= '0;
      gen      <= '0;
      wbable   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        st[i]     <= LQ_FREE;
        mat[i]    <= '0;
        paddr[i]  <= '0;
        wbaddr[i] <= '0;
        robptr[i] <= '0;
      end
    end else begin
      st <= st_n;
      if (lq.Flush) begin
        head     <= '0;
        tail     <= '0;
        bar_pend <= 1'b0;
        iss_lock <= 1'b0;
      end else if (!lq.Stall) begin
        head     <= head + (IW + 1)'(lq.RetireCnt);
        bar_pend <= bar_pend ? ~(empty & lq.SbEmpty) : bar_req;
        iss_lock <= lq.DcReqValid & ~lq.DcReqReady;
        iss_hold <= iss_idx;
        if (alloc) begin
          tail             <= tail + 1'b1;
          gen[tail_idx]    <= ~gen[tail_idx];
          mat[tail_idx]    <= lq.InMat;
          paddr[tail_idx]  <= lq.InPAddr;
          wbable[tail_idx] <= lq.InWbAble;
          wbaddr[tail_idx] <= lq.InWbAddr;
          robptr[tail_idx] <= lq.InRobPtr;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_queue.sv
// tb/tb_load_queue.sv - directed self-checking bench for load_queue
module tb_load_queue;

  logic        Clk = 1'b0;
  logic        Rest;
  int          passed = 0;
  int          total  = 0;
  logic [31:0] wb_data;

  load_queue_if #(.DEPTH(8)) lq ();

  load_queue #(.DEPTH(8)) dut (
    .Clk  (Clk),
    .Rest (Rest),
    .lq   (lq)
  );

  always #5 Clk = ~Clk;

  assign wb_data = lq.WbValid ? lq.DcRespData : 32'd0;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic resp(input logic [3:0] tag, input logic nack);
    lq.DcRespValid = 1'b1;
    lq.DcRespTag   = tag;
    lq.DcRespNack  = nack;
  endtask

  task automatic load_in(input logic [31:0] addr, input logic [5:0] rob, input logic [6:0] wba,
                         input logic wbe);
    lq.InValid  = 1'b1;
    lq.InBar    = 1'b0;
    lq.InPAddr  = addr;
    lq.InRobPtr = rob;
    lq.InWbAddr = wba;
    lq.InWbAble = wbe;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rest = 1'b1;
    lq.Stall = 0; lq.Flush = 0; lq.SbEmpty = 1; lq.InValid = 0; lq.InBar = 0; lq.InMat = 2'd1;
    lq.InPAddr = 0; lq.InWbAble = 0; lq.InWbAddr = 0; lq.InRobPtr = 0; lq.DcReqReady = 0;
    lq.DcRespValid = 0; lq.DcRespTag = 0; lq.DcRespNack = 0; lq.DcRespData = 32'hBEEF;
    lq.RetireCnt = 0;
    tick(); tick();
    Rest = 1'b0;
    #1;
    chk("rst_stop", lq.StopReq, 0);
    chk("rst_dcvalid", lq.DcReqValid, 0);
    chk("rst_cmt", lq.CmtValid, 0);
    chk("rst_wb", lq.WbValid, 0);
    chk("rst_tag", lq.DcReqTag, 0);
    lq.InValid = 1; lq.InBar = 1;
    #1;
    chk("rst_bar_stop", lq.StopReq, 1);
    lq.InValid = 0; lq.InBar = 0;

    // Fill all eight entries with no Dcache acceptance.
    for (int i = 0; i < 8; i++) begin
      load_in(32'h1000 + 32'(16 * i), 6'(10 + i), 7'(20 + i), (i != 3));
      #1;
      chk($sformatf("fill_stop%0d", i), lq.StopReq, 0);
      tick();
    end
    #1;
    chk("full_stop", lq.StopReq, 1);
    lq.InValid = 0;
    tick();
    chk("full_hold", lq.StopReq, 1);
    chk("head_tag", lq.DcReqTag, 4'h8);
    chk("head_addr", lq.DcReqAddr, 32'h1000);

    // Issue entries 0 and 1, respond out of order.
    lq.DcReqReady = 1;
    tick();
    chk("iss1_tag", lq.DcReqTag, 4'h9);
    chk("iss1_addr", lq.DcReqAddr, 32'h1010);
    tick();
    lq.DcReqReady = 0;
    resp(4'h9, 0);
    #1;
    chk("rsp1_cmt", lq.CmtValid, 1);
    chk("rsp1_rob", lq.CmtRobPtr, 11);
    chk("rsp1_wb", lq.WbValid, 1);
    chk("rsp1_wbaddr", lq.WbAddr, 21);
    chk("rsp1_wbdata", wb_data, 32'hBEEF);
    tick();
    resp(4'h8, 0);
    #1;
    chk("rsp0_cmt", lq.CmtValid, 1);
    chk("rsp0_rob", lq.CmtRobPtr, 10);
    tick();
    resp(4'h8, 0);
    #1;
    chk("dup_drop", lq.CmtValid, 0);
    tick();
    lq.DcRespValid = 0;

    // Entry 2 nacked while stalled must reissue ahead of entry 3.
    lq.DcReqReady = 1;
    #1;
    chk("iss2_tag", lq.DcReqTag, 4'hA);
    tick();
    lq.DcReqReady = 0;
    lq.Stall = 1;
    resp(4'hA, 1);
    #1;
    chk("stall_gate", lq.DcReqValid, 0);
    chk("nack_cmt", lq.CmtValid, 0);
    tick();
    lq.Stall = 0;
    lq.DcRespValid = 0;
    #1;
    chk("reiss_valid", lq.DcReqValid, 1);
    chk("reiss_tag", lq.DcReqTag, 4'hA);
    chk("reiss_addr", lq.DcReqAddr, 32'h1020);
    lq.DcReqReady = 1;
    tick();
    lq.DcReqReady = 0;
    #1;
    chk("younger_tag", lq.DcReqTag, 4'hB);
    chk("younger_addr", lq.DcReqAddr, 32'h1030);

    lq.RetireCnt = 2;
    tick();
    lq.RetireCnt = 0;
    #1;
    chk("retire_unfull", lq.StopReq, 0);

    // Entry 3 does not write a register.
    lq.DcReqReady = 1;
    tick();
    lq.DcReqReady = 0;
    resp(4'hB, 0);
    #1;
    chk("rsp3_cmt", lq.CmtValid, 1);
    chk("rsp3_rob", lq.CmtRobPtr, 13);
    chk("rsp3_nowb", lq.WbValid, 0);
    tick();
    lq.DcRespValid = 0;

    lq.Flush = 1;
    tick();
    lq.Flush = 0;
    #1;
    chk("flush_dcvalid", lq.DcReqValid, 0);
    chk("flush_stop", lq.StopReq, 0);

    // Stale generation after flush and reallocation.
    load_in(32'h2000, 6'd40, 7'd50, 1);
    tick();
    lq.InValid = 0;
    #1;
    chk("gen0_tag", lq.DcReqTag, 4'h0);
    lq.DcReqReady = 1;
    tick();
    lq.DcReqReady = 0;
    lq.Flush = 1;
    tick();
    lq.Flush = 0;
    load_in(32'h3000, 6'd41, 7'd51, 1);
    tick();
    lq.InValid = 0;
    #1;
    chk("gen1_tag", lq.DcReqTag, 4'h8);
    chk("gen1_addr", lq.DcReqAddr, 32'h3000);
    lq.DcReqReady = 1;
    tick();
    lq.DcReqReady = 0;
    resp(4'h0, 0);
    #1;
    chk("stale_drop", lq.CmtValid, 0);
    tick();
    resp(4'h8, 0);
    #1;
    chk("fresh_rob", lq.CmtRobPtr, 41);
    tick();
    lq.DcRespValid = 0;

    // Barrier with three live entries and a busy store buffer.
    load_in(32'h4000, 6'd42, 7'd52, 1);
    tick();
    load_in(32'h4010, 6'd43, 7'd53, 1);
    tick();
    lq.SbEmpty = 0;
    lq.InValid = 1; lq.InBar = 1;
    #1;
    chk("bar_req_stop", lq.StopReq, 1);
    tick();
    lq.InValid = 0; lq.InBar = 0;
    #1;
    chk("bar_hold", lq.StopReq, 1);
    lq.DcReqReady = 1;
    tick(); tick();
    lq.DcReqReady = 0;
    resp(4'h1, 0);
    #1;
    chk("bar_rsp_rob", lq.CmtRobPtr, 42);
    tick();
    resp(4'h2, 0);
    tick();
    lq.DcRespValid = 0;
    lq.RetireCnt = 3;
    tick();
    lq.RetireCnt = 0;
    #1;
    chk("bar_sb_busy", lq.StopReq, 1);
    tick();
    chk("bar_sb_busy2", lq.StopReq, 1);
    lq.SbEmpty = 1;
    #1;
    chk("bar_clear_lag", lq.StopReq, 1);
    tick();
    chk("bar_release", lq.StopReq, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
